// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared display package: default sizing for the sprite ROM arbiter,
// requester-index width helper and the arbiter run-phase type.
package sprite_rom_arbiter_pkg;

  localparam int unsigned N_REQ_DEF   = 4;   // number of requesters
  localparam int unsigned AW_DEF      = 14;  // sprite ROM address width
  localparam int unsigned DW_DEF      = 12;  // 12-bit RGB pixel
  localparam int unsigned ROM_LAT_DEF = 1;   // ROM read latency in clocks

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_width(N_REQ_DEF);

  // Arbitration is held off for the first cycle after reset releases.
  typedef enum logic {
    ARB_HALT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_phase_e;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: scans the eligible mask starting one
// past the last granted index and returns the first hit as a one-hot.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  winner,
  output logic          valid
);

  // Priority by distance from last: offset 1 first, offset N (last itself) final.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!valid && eligible[i] && (i == ((32'(last) + off) % N))) begin
          winner[i] = 1'b1;
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: round-robin shares one synchronous sprite ROM among
// N_REQ requesters and steers each read result back to its requester.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned ROM_LAT = ROM_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arb_en,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    grant,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic [N_REQ-1:0]    rd_valid,
  output logic [DW-1:0]       rd_data,
  output logic                busy
);

  localparam int unsigned IW = idx_width(N_REQ);

  arb_phase_e       phase;
  logic [IW-1:0]    last_idx;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] winner;
  logic             win_valid;
  logic [IW-1:0]    win_idx;
  logic [AW-1:0]    win_addr;
  logic             pipe_any;

  // One-hot requester tags, one stage per ROM latency clock.
  logic [N_REQ-1:0] tag_pipe [ROM_LAT];

  // A requester whose grant is showing this cycle is not eligible again.
  always_comb begin
    eligible = '0;
    if (phase == ARB_RUN && arb_en) begin
      eligible = req & ~grant;
    end
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .eligible (eligible),
    .last     (last_idx),
    .winner   (winner),
    .valid    (win_valid)
  );

  // Winner index and its address from the one-hot pick.
  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner[i]) begin
        win_idx  = IW'(i);
        win_addr = req_addr[i*AW +: AW];
      end
    end
  end

  // Arbitration state: registered grant pulse, ROM address and last winner.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase    <= ARB_HALT;
      grant    <= '0;
      rom_addr <= '0;
      last_idx <= IW'(N_REQ - 1);
    end else begin
      phase <= ARB_RUN;
      grant <= winner;
      if (win_valid) begin
        rom_addr <= win_addr;
        last_idx <= win_idx;
      end
    end
  end

  // Tag shift register: a grant re-emerges as rd_valid ROM_LAT clocks later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < ROM_LAT; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0] <= grant;
      for (int unsigned k = 1; k < ROM_LAT; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  // Busy whenever a grant is showing or any tag is still travelling.
  always_comb begin
    pipe_any = 1'b0;
    for (int unsigned k = 0; k < ROM_LAT; k++) begin
      pipe_any = pipe_any | (|tag_pipe[k]);
    end
    busy = (|grant) | pipe_any;
  end

  assign rd_valid = tag_pipe[ROM_LAT-1];
  assign rd_data  = (|rd_valid) ? rom_data : '0;

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, 4, number of requesters; AW, 14, ROM address width; DW, 12, ROM data width (12-bit RGB); ROM_LAT, 1, sprite ROM read latency in clocks.
REQ-002 clk  input  1  system clock; the only clock.
REQ-003 reset  input  1  reset; synchronous, active-low.
REQ-004 arb_en  input  1  when 1, new grants are allowed; when 0, no new grant is issued and in-flight reads complete.
REQ-005 req  input  N_REQ  per-requester read request; held high until grant is seen.
REQ-006 req_addr  input  N_REQ*AW  flattened addresses; requester i uses bits [i*AW +: AW]; stable while req[i]=1.
REQ-007 grant  output  N_REQ  one-hot, one-cycle grant pulse.
REQ-008 rom_addr  output  AW  address to the shared synchronous sprite ROM.
REQ-009 rom_data  input  DW  ROM read data, valid ROM_LAT cycles after rom_addr.
REQ-010 rd_valid  output  N_REQ  one-hot, one-cycle pulse marking rd_data for requester i.
REQ-011 rd_data  output  DW  returned pixel color, equal to rom_data in the rd_valid cycle.
REQ-012 busy  output  1  1 while any read is in flight.

Function
REQ-013 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod N_REQ; first eligible req wins.
REQ-014 Eligible SHALL mean req[i]=1, arb_en=1, and grant[i]=0 in the current cycle (no double grant from a held req).
REQ-015 At most one grant SHALL be issued per cycle; a grant every cycle SHALL be sustainable.
REQ-016 Decision in cycle t SHALL register grant[i]=1 and rom_addr=req_addr[i] in cycle t+1.
REQ-017 rd_valid[i] SHALL pulse in cycle t+1+ROM_LAT, with rd_data=rom_data; responses return in grant order.
REQ-018 Requester tags SHALL travel in a ROM_LAT-deep shift register alongside the read; no other buffering.
REQ-019 When no grant is issued, rom_addr SHALL hold its last value and grant SHALL be 0.
REQ-020 last_granted SHALL update only on an actual grant.
REQ-021 arb_en falling SHALL not cancel an already registered grant or its rd_valid.
REQ-022 busy SHALL be 1 in any cycle where grant!=0 or a tag is in the shift register.
REQ-023 Requester dropping req before grant SHALL receive nothing; no partial state is kept.
REQ-024 Wrap-around: after granting N_REQ-1, the search SHALL start at 0.

Reset
REQ-025 With reset=0 at a clk edge: grant=0, rd_valid=0, rd_data=0, rom_addr=0, busy=0, tag pipeline cleared, last_granted=N_REQ-1 (requester 0 wins first).
REQ-026 Reset mid-operation SHALL discard in-flight reads; no rd_valid SHALL pulse for them after reset releases.
REQ-027 First grant after release SHALL be no earlier than the cycle after the first edge with reset=1.

Structure
REQ-028 N_REQ, AW, DW, ROM_LAT defaults and the requester-index width SHALL live in a shared display package.
REQ-029 Round-robin selection SHALL be one combinational sub-module, rr_pick (inputs eligible mask, last index; outputs one-hot winner, valid).
REQ-030 The ROM itself SHALL stay outside this block.

Verification
REQ-031 Single: req=0001, addr0=0x0123 at t -> grant=0001, rom_addr=0x0123 at t+1; rd_valid=0001, rd_data=ROM[0x0123] at t+2.
REQ-032 All four held high from reset -> grants 0001,0010,0100,1000,0001 on consecutive grant slots; no requester granted twice in adjacent cycles.
REQ-033 Held req: req=0010 held 4 cycles alone -> grant pattern 0010,0000,0010,0000; rd_valid mirrors it ROM_LAT later.
REQ-034 arb_en=0 in the cycle after a grant -> that rd_valid still arrives; no further grant until arb_en=1; busy falls after rd_valid.
REQ-035 reset=0 asserted in the cycle after grant=0100 -> rd_valid stays 0000; next grant with req=1111 is 0001.
REQ-036 Random reqs/addrs, 10k cycles, scoreboard -> every rd_data equals ROM[addr] for the tagged requester, in order, grant always one-hot or zero.
